reg_file_wr_arbiter: RTL

//  Shares the single write port (Caddr/C/load) of the 16x16 register file between two

---
 rtl/reg_file_wr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter for the register-file write port, with a zeroing scrub sequence.
// Grant to rf_load takes 1 cycle; ready is combinational and only one requester is granted at a time.
module reg_file_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              scrub_req,
  output logic              scrub_busy,
  output logic [ADDR_W-1:0] rf_Caddr,
  output logic [DATA_W-1:0] rf_C,
  output logic              rf_load
);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last1;
  logic              gnt0;
  logic              gnt1;

  // last1 set means req1 won the previous grant, so req0 is favoured next
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!clear && state == IDLE && !scrub_req) begin
      gnt0 = req0_valid & (~req1_valid | last1);
      gnt1 = req1_valid & (~req0_valid | ~last1);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      last1      <= 1'b1;
      rf_load    <= 1'b0;
      rf_Caddr   <= '0;
      rf_C       <= '0;
      scrub_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scrub_req) begin
            state      <= SCRUB;
            cnt        <= '0;
            rf_load    <= 1'b0;
            scrub_busy <= 1'b1;
          end else begin
            scrub_busy <= 1'b0;
            rf_load    <= gnt0 | gnt1;
            if (gnt0) begin
              rf_Caddr <= req0_addr;
              rf_C     <= req0_data;
              last1    <= 1'b0;
            end else if (gnt1) begin
              rf_Caddr <= req1_addr;
              rf_C     <= req1_data;
              last1    <= 1'b1;
            end
          end
        end
        SCRUB: begin
          // busy stays high through the cycle that shows the final scrub write
          scrub_busy <= 1'b1;
          rf_load    <= 1'b1;
          rf_Caddr   <= cnt;
          rf_C       <= '0;
          if (cnt == ADDR_W'(NREGS - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
